score_keeper: RTL and testbench

Consumes the per-frame pellet status (pellet_collected, all_pellets_cleared) from the pellet store, plus ghost and death events, and runs the game-flow FSM. Maintains the 6-digit BCD score, high score, lives and level. Drives the pellet-store refill (level_reset), Pac-Man/ghost respawn, and the play_enable gate for the movement logic. Sits between the pellet store and the HUD/sprite renderer.

---
 rtl/pacman_pkg.sv | 32 +++
 rtl/bcd_add6.sv | 37 +++
 rtl/score_keeper.sv | 230 +++++++++++++++++++++++
 tb/tb_score_keeper.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// pacman_pkg: shared types and constants for the Pac-Man game-flow logic.
//   game_state_t : PLAY / LEVEL_CLEAR / DEATH / GAME_OVER (encoding is visible
//                  on the score_keeper game_state port, so it must not move)
//   COMBO_*      : BCD point values of the ghost-eating combo ladder
//   SCORE_MAX    : saturating ceiling of the 6-digit BCD score
//   combo_next() : next rung of the combo ladder (1600 holds)
package pacman_pkg;

    typedef enum logic [1:0] {
        PLAY        = 2'd0,
        LEVEL_CLEAR = 2'd1,
        DEATH       = 2'd2,
        GAME_OVER   = 2'd3
    } game_state_t;

    localparam logic [23:0] COMBO_200  = 24'h000200;
    localparam logic [23:0] COMBO_400  = 24'h000400;
    localparam logic [23:0] COMBO_800  = 24'h000800;
    localparam logic [23:0] COMBO_1600 = 24'h001600;
    localparam logic [23:0] SCORE_MAX  = 24'h999999;

    function automatic logic [23:0] combo_next(input logic [23:0] c);
        logic [23:0] n;
        case (c)
            COMBO_200: n = COMBO_400;
            COMBO_400: n = COMBO_800;
            default:   n = COMBO_1600;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/bcd_add6.sv
// bcd_add6: combinational 6-digit packed-BCD adder.
// Ports:
//   a_i    [23:0] in  addend, valid BCD
//   b_i    [23:0] in  addend, valid BCD
//   sum_o  [23:0] out BCD sum modulo 10^6
//   sat_o         out carry out of the top digit (sum exceeded 999999);
//                     the caller uses it to saturate
module bcd_add6 (
    input  logic [23:0] a_i,
    input  logic [23:0] b_i,
    output logic [23:0] sum_o,
    output logic        sat_o
);

    logic [4:0] dig;
    logic       cy;

    // Ripple digit by digit: a binary digit sum above 9 is corrected by +6,
    // which pushes it past 15 so the low nibble wraps to the right BCD digit.
    always_comb begin
        sum_o = '0;
        dig   = '0;
        cy    = 1'b0;
        for (int i = 0; i < 6; i++) begin
            dig = {1'b0, a_i[i*4 +: 4]} + {1'b0, b_i[i*4 +: 4]} + {4'd0, cy};
            if (dig > 5'd9) begin
                dig = dig + 5'd6;
                cy  = 1'b1;
            end else begin
                cy  = 1'b0;
            end
            sum_o[i*4 +: 4] = dig[3:0];
        end
        sat_o = cy;
    end

endmodule

// File: rtl/score_keeper.sv
// score_keeper: Pac-Man game-flow FSM with BCD score, high score, lives, level.
// Build option: define SCORE_EXTRA_LIFE_EN to award one bonus life per game
// when the score first reaches EXTRA_LIFE_AT.
// Ports:
//   clk, reset (sync, active-high)
//   frame_clk            in  one-cycle frame strobe; game events count only here
//   pellet_collected     in  pellet taken this frame
//   all_pellets_cleared  in  last pellet of the level taken
//   power_start          in  power pellet eaten; restarts the ghost combo
//   ghost_eaten          in  frightened ghost eaten (at most one per frame)
//   pacman_caught        in  caught by a non-frightened ghost
//   start_btn            in  start request (sampled every clk in GAME_OVER)
//   score/high_score     out 6-digit BCD
//   lives [2:0], level [7:0] (binary)
//   game_state [1:0]     out current FSM state (PLAY=0 .. GAME_OVER=3)
//   play_enable          out high while in PLAY
//   level_reset, respawn out registered one-clk pulses
module score_keeper
    import pacman_pkg::*;
#(
    parameter int          START_LIVES   = 3,
    parameter int          CLEAR_FRAMES  = 120,
    parameter int          DEATH_FRAMES  = 90,
    parameter logic [23:0] PELLET_PTS    = 24'h000010,
    parameter logic [23:0] EXTRA_LIFE_AT = 24'h010000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_clk,
    input  logic        pellet_collected,
    input  logic        all_pellets_cleared,
    input  logic        power_start,
    input  logic        ghost_eaten,
    input  logic        pacman_caught,
    input  logic        start_btn,
    output logic [23:0] score,
    output logic [23:0] high_score,
    output logic [2:0]  lives,
    output logic [7:0]  level,
    output logic [1:0]  game_state,
    output logic        play_enable,
    output logic        level_reset,
    output logic        respawn
);

    localparam logic [15:0] CLEAR_LAST = 16'(CLEAR_FRAMES - 1);
    localparam logic [15:0] DEATH_LAST = 16'(DEATH_FRAMES - 1);
    localparam logic [2:0]  LIVES_INIT = 3'(START_LIVES);

    game_state_t state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [23:0] score_q, score_d;
    logic [23:0] high_q;
    logic [23:0] combo_q, combo_d;
    logic [2:0]  lives_q, lives_d;
    logic [7:0]  level_q, level_d;
    logic        level_reset_q, level_reset_d;
    logic        respawn_q, respawn_d;

    logic [23:0] incr;
    logic [23:0] add_sum;
    logic        add_sat;
    logic [23:0] score_plus;

    // Pellet points live in the tens digit and combo values in hundreds and
    // up, so OR-ing them forms the BCD sum without an extra adder.
    assign incr = (pellet_collected ? PELLET_PTS : 24'h0) |
                  (ghost_eaten      ? combo_q    : 24'h0);

    bcd_add6 u_add (
        .a_i   (score_q),
        .b_i   (incr),
        .sum_o (add_sum),
        .sat_o (add_sat)
    );

    assign score_plus = add_sat ? SCORE_MAX : add_sum;

`ifdef SCORE_EXTRA_LIFE_EN
    logic extra_q, extra_d;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        score_d       = score_q;
        combo_d       = combo_q;
        lives_d       = lives_q;
        level_d       = level_q;
        level_reset_d = 1'b0;
        respawn_d     = 1'b0;

        // A power pellet restarts the combo in every state; in PLAY it also
        // wins over a same-frame doubling because the doubling below is
        // suppressed when power_start is present.
        if (frame_clk && power_start) begin
            combo_d = COMBO_200;
        end

        unique case (state_q)
            PLAY: begin
                if (frame_clk) begin
                    if (all_pellets_cleared) begin
                        score_d = score_plus;
                        if (ghost_eaten && !power_start) combo_d = combo_next(combo_q);
                        state_d = LEVEL_CLEAR;
                        cnt_d   = '0;
                    end else if (pacman_caught) begin
                        // Caught this frame: nothing scored.
                        state_d = DEATH;
                        cnt_d   = '0;
                    end else begin
                        score_d = score_plus;
                        if (ghost_eaten && !power_start) combo_d = combo_next(combo_q);
                    end
                end
            end

            LEVEL_CLEAR: begin
                if (frame_clk) begin
                    if (cnt_q == CLEAR_LAST) begin
                        if (level_q != 8'hFF) level_d = level_q + 8'd1;
                        combo_d       = COMBO_200;
                        level_reset_d = 1'b1;
                        respawn_d     = 1'b1;
                        state_d       = PLAY;
                        cnt_d         = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end

            DEATH: begin
                if (frame_clk) begin
                    if (cnt_q == DEATH_LAST) begin
                        if (lives_q <= 3'd1) begin
                            lives_d = 3'd0;
                            state_d = GAME_OVER;
                        end else begin
                            lives_d   = lives_q - 3'd1;
                            respawn_d = 1'b1;
                            state_d   = PLAY;
                        end
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end

            GAME_OVER: begin
                if (start_btn) begin
                    score_d       = '0;
                    lives_d       = LIVES_INIT;
                    level_d       = 8'd1;
                    combo_d       = COMBO_200;
                    level_reset_d = 1'b1;
                    respawn_d     = 1'b1;
                    state_d       = PLAY;
                    cnt_d         = '0;
                end
            end

            default: state_d = GAME_OVER;
        endcase

`ifdef SCORE_EXTRA_LIFE_EN
        extra_d = extra_q;
        if (state_q == GAME_OVER && start_btn) begin
            extra_d = 1'b0;
        end else if (state_q == PLAY && frame_clk && !extra_q &&
                     score_d >= EXTRA_LIFE_AT) begin
            extra_d = 1'b1;
            if (lives_q != 3'd7) lives_d = lives_q + 3'd1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= GAME_OVER;
            cnt_q         <= '0;
            score_q       <= '0;
            combo_q       <= COMBO_200;
            lives_q       <= LIVES_INIT;
            level_q       <= 8'd1;
            level_reset_q <= 1'b0;
            respawn_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            score_q       <= score_d;
            combo_q       <= combo_d;
            lives_q       <= lives_d;
            level_q       <= level_d;
            level_reset_q <= level_reset_d;
            respawn_q     <= respawn_d;
        end
    end

    // Packed BCD orders the same as binary, so a plain compare is enough.
    always_ff @(posedge clk) begin
        if (reset) begin
            high_q <= '0;
        end else if (score_q > high_q) begin
            high_q <= score_q;
        end
    end

`ifdef SCORE_EXTRA_LIFE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            extra_q <= 1'b0;
        end else begin
            extra_q <= extra_d;
        end
    end
`endif

    assign score       = score_q;
    assign high_score  = high_q;
    assign lives       = lives_q;
    assign level       = level_q;
    assign game_state  = state_q;
    assign play_enable = (state_q == PLAY);
    assign level_reset = level_reset_q;
    assign respawn     = respawn_q;

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: directed scoreboard bench for score_keeper.
// The driver pushes the expected DUT view into exp_q and raises chk_req on the
// same cycle; the monitor pops one entry on the falling edge after each
// flagged posedge. A second monitor measures level_reset/respawn pulses.
module tb_score_keeper;

    typedef struct packed {
        logic [23:0] score;
        logic [23:0] hi;
        logic        hi_en;
        logic [2:0]  lives;
        logic [7:0]  level;
        logic [1:0]  st;
        logic        pe;
    } exp_t;

`ifdef SCORE_EXTRA_LIFE_EN
    localparam int L = 4;
`else
    localparam int L = 3;
`endif

    logic        clk;
    logic        reset;
    logic        frame_clk;
    logic        pellet_collected;
    logic        all_pellets_cleared;
    logic        power_start;
    logic        ghost_eaten;
    logic        pacman_caught;
    logic        start_btn;
    logic [23:0] score;
    logic [23:0] high_score;
    logic [2:0]  lives;
    logic [7:0]  level;
    logic [1:0]  game_state;
    logic        play_enable;
    logic        level_reset;
    logic        respawn;

    exp_t exp_q[$];
    logic chk_req;
    logic chk_pend;
    int   checks;
    int   errors;
    int   lr_cnt, rs_cnt, lr_w, rs_w;

    score_keeper dut (
        .clk                 (clk),
        .reset               (reset),
        .frame_clk           (frame_clk),
        .pellet_collected    (pellet_collected),
        .all_pellets_cleared (all_pellets_cleared),
        .power_start         (power_start),
        .ghost_eaten         (ghost_eaten),
        .pacman_caught       (pacman_caught),
        .start_btn           (start_btn),
        .score               (score),
        .high_score          (high_score),
        .lives               (lives),
        .level               (level),
        .game_state          (game_state),
        .play_enable         (play_enable),
        .level_reset         (level_reset),
        .respawn             (respawn)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) chk_pend <= chk_req;

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (chk_pend) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL underflow: DUT output sampled with empty expected queue");
            end else begin
                e = exp_q.pop_front();
                if (score !== e.score || lives !== e.lives || level !== e.level ||
                    game_state !== e.st || play_enable !== e.pe ||
                    (e.hi_en && high_score !== e.hi)) begin
                    errors++;
                    $display("FAIL state @%0t: got score=%h hi=%h lives=%0d level=%0d st=%0d pe=%0b, want score=%h hi=%h(chk=%0b) lives=%0d level=%0d st=%0d pe=%0b",
                             $time, score, high_score, lives, level, game_state, play_enable,
                             e.score, e.hi, e.hi_en, e.lives, e.level, e.st, e.pe);
                end
            end
        end
    end

    // Pulse monitor: counts pulses and checks each is exactly one clk wide.
    always @(negedge clk) begin
        if (level_reset) lr_w++;
        else if (lr_w != 0) begin
            checks++;
            lr_cnt++;
            if (lr_w != 1) begin
                errors++;
                $display("FAIL level_reset_width: got %0d clks, want 1", lr_w);
            end
            lr_w = 0;
        end
        if (respawn) rs_w++;
        else if (rs_w != 0) begin
            checks++;
            rs_cnt++;
            if (rs_w != 1) begin
                errors++;
                $display("FAIL respawn_width: got %0d clks, want 1", rs_w);
            end
            rs_w = 0;
        end
    end

    // ---------------- helpers / driver ----------------
    function automatic exp_t mk(input logic [23:0] s, input logic [23:0] h, input logic h_en,
                                input int lv, input int lvl, input int st);
        exp_t e;
        e.score = s;
        e.hi    = h;
        e.hi_en = h_en;
        e.lives = 3'(lv);
        e.level = 8'(lvl);
        e.st    = 2'(st);
        e.pe    = (st == 0);
        return e;
    endfunction

    function automatic int bcd2i(input logic [23:0] b);
        int r = 0;
        for (int i = 5; i >= 0; i--) r = r * 10 + int'(b[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [23:0] i2bcd(input int v);
        logic [23:0] r = '0;
        int t = v;
        for (int i = 0; i < 6; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic clear_inputs();
        frame_clk = 0; pellet_collected = 0; all_pellets_cleared = 0;
        power_start = 0; ghost_eaten = 0; pacman_caught = 0; start_btn = 0;
        chk_req = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input logic pc, input logic ac, input logic ps, input logic ge,
                         input logic pk, input exp_t e);
        @(negedge clk);
        frame_clk = 1; pellet_collected = pc; all_pellets_cleared = ac;
        power_start = ps; ghost_eaten = ge; pacman_caught = pk;
        exp_q.push_back(e);
        chk_req = 1;
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic probe(input exp_t e);
        @(negedge clk);
        exp_q.push_back(e);
        chk_req = 1;
        @(negedge clk);
        chk_req = 0;
    endtask

    task automatic press_start(input exp_t e);
        @(negedge clk);
        start_btn = 1;
        exp_q.push_back(e);
        chk_req = 1;
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic check_cnt(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int s;
        int combo;
        logic [23:0] last;

        checks = 0; errors = 0;
        lr_cnt = 0; rs_cnt = 0; lr_w = 0; rs_w = 0;
        clear_inputs();
        reset = 1;
        repeat (3) @(negedge clk);
        reset = 0;

        // Reset state
        probe(mk(24'h0, 24'h0, 1, 3, 1, 3));

        // New game
        press_start(mk(24'h0, 24'h0, 0, 3, 1, 0));
        idle(2);
        check_cnt("start_level_reset_pulses", lr_cnt, 1);
        check_cnt("start_respawn_pulses", rs_cnt, 1);

        // Three pellets
        frame(1, 0, 0, 0, 0, mk(24'h000010, 0, 0, 3, 1, 0));
        frame(1, 0, 0, 0, 0, mk(24'h000020, 0, 0, 3, 1, 0));
        frame(1, 0, 0, 0, 0, mk(24'h000030, 0, 0, 3, 1, 0));
        idle(2);
        probe(mk(24'h000030, 24'h000030, 1, 3, 1, 0));

        // Power pellet then five ghosts: +200,400,800,1600,1600
        frame(0, 0, 1, 0, 0, mk(24'h000030, 0, 0, 3, 1, 0));
        frame(0, 0, 0, 1, 0, mk(24'h000230, 0, 0, 3, 1, 0));
        frame(0, 0, 0, 1, 0, mk(24'h000630, 0, 0, 3, 1, 0));
        frame(0, 0, 0, 1, 0, mk(24'h001430, 0, 0, 3, 1, 0));
        frame(0, 0, 0, 1, 0, mk(24'h003030, 0, 0, 3, 1, 0));
        frame(0, 0, 0, 1, 0, mk(24'h004630, 0, 0, 3, 1, 0));

        // Combo restart, pellet+ghost with combo 400, power beats doubling
        frame(0, 0, 1, 0, 0, mk(24'h004630, 0, 0, 3, 1, 0));
        frame(0, 0, 0, 1, 0, mk(24'h004830, 0, 0, 3, 1, 0));
        frame(1, 0, 0, 1, 0, mk(24'h005240, 0, 0, 3, 1, 0));
        frame(0, 0, 1, 1, 0, mk(24'h006040, 0, 0, 3, 1, 0));
        frame(0, 0, 0, 1, 0, mk(24'h006240, 0, 0, 3, 1, 0));
        frame(0, 0, 0, 1, 0, mk(24'h006640, 0, 0, 3, 1, 0));
        frame(0, 0, 0, 1, 0, mk(24'h007440, 0, 0, 3, 1, 0));
        frame(0, 0, 0, 1, 0, mk(24'h009040, 0, 0, 3, 1, 0));
        // Crosses 010000: bonus life only when the feature is built in
        frame(0, 0, 0, 1, 0, mk(24'h010640, 0, 0, L, 1, 0));
        frame(0, 0, 0, 1, 0, mk(24'h012240, 0, 0, L, 1, 0));

        // Clear and caught in the same frame: clear wins, pellet still scores
        frame(1, 1, 0, 0, 1, mk(24'h012250, 0, 0, L, 1, 1));
        for (int i = 1; i <= 120; i++) begin
            frame(1, 0, 0, 1, 0, mk(24'h012250, 0, 0, L, (i == 120) ? 2 : 1, (i == 120) ? 0 : 1));
        end
        idle(3);
        check_cnt("clear_level_reset_pulses", lr_cnt, 2);
        check_cnt("clear_respawn_pulses", rs_cnt, 2);

        // First death: no points on the caught frame, then respawn
        frame(1, 0, 0, 0, 1, mk(24'h012250, 0, 0, L, 2, 2));
        for (int i = 1; i <= 90; i++) begin
            frame(1, 0, 0, 1, 0, mk(24'h012250, 0, 0, (i == 90) ? L - 1 : L, 2, (i == 90) ? 0 : 2));
        end
        idle(3);
        check_cnt("death_respawn_pulses", rs_cnt, 3);
        check_cnt("death_level_reset_pulses", lr_cnt, 2);

        // Drive the score into saturation with pellet+ghost frames
        s = bcd2i(24'h012250);
        combo = 200;
        while (s < 999999) begin
            s = s + 10 + combo;
            if (s > 999999) s = 999999;
            combo = (combo >= 800) ? 1600 : combo * 2;
            frame(1, 0, 0, 1, 0, mk(i2bcd(s), 0, 0, L - 1, 2, 0));
        end
        last = 24'h999999;
        frame(1, 0, 0, 0, 0, mk(last, 0, 0, L - 1, 2, 0));
        idle(2);
        probe(mk(24'h999999, 24'h999999, 1, L - 1, 2, 0));

        // Remaining deaths down to game over
        for (int d = L - 1; d >= 1; d--) begin
            frame(0, 0, 0, 0, 1, mk(24'h999999, 0, 0, d, 2, 2));
            for (int i = 1; i <= 90; i++) begin
                if (i < 90)
                    frame(1, 0, 0, 0, 0, mk(24'h999999, 0, 0, d, 2, 2));
                else if (d == 1)
                    frame(1, 0, 0, 0, 0, mk(24'h999999, 0, 0, 0, 2, 3));
                else
                    frame(1, 0, 0, 0, 0, mk(24'h999999, 0, 0, d - 1, 2, 0));
            end
        end
        idle(3);
        check_cnt("gameover_respawn_pulses", rs_cnt, L + 1);
        check_cnt("gameover_level_reset_pulses", lr_cnt, 2);
        probe(mk(24'h999999, 24'h999999, 1, 0, 2, 3));

        // Restart keeps high score
        press_start(mk(24'h0, 0, 0, 3, 1, 0));
        idle(2);
        probe(mk(24'h0, 24'h999999, 1, 3, 1, 0));
        check_cnt("restart_level_reset_pulses", lr_cnt, 3);
        check_cnt("restart_respawn_pulses", rs_cnt, L + 2);

        // Reset in the middle of DEATH: back to reset values, no pulse
        frame(1, 0, 0, 0, 0, mk(24'h000010, 0, 0, 3, 1, 0));
        frame(0, 0, 0, 0, 1, mk(24'h000010, 0, 0, 3, 1, 2));
        for (int i = 0; i < 5; i++) frame(0, 0, 0, 0, 0, mk(24'h000010, 0, 0, 3, 1, 2));
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        probe(mk(24'h0, 24'h0, 1, 3, 1, 3));
        idle(3);
        check_cnt("reset_abort_respawn_pulses", rs_cnt, L + 2);
        check_cnt("reset_abort_level_reset_pulses", lr_cnt, 3);

        idle(2);
        check_cnt("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
